// File: rtl/encoder_pkg.sv
// ---------------------------------------------------------------------------
// encoder_pkg
//  Shared definitions for the multi-channel quadrature encoder peripheral:
//  global register offsets, per-channel window (base 0x20, stride 0x10) and
//  the offsets inside it, STATUS / IRQ_STATUS bit positions, the x4 step
//  classification and the Gray-code helpers used by the decoder.
// ---------------------------------------------------------------------------
package encoder_pkg;

    // Global registers (byte offsets, low address byte only)
    localparam logic [7:0] REG_CTRL       = 8'h00;
    localparam logic [7:0] REG_CLR        = 8'h04;
    localparam logic [7:0] REG_IRQ_STATUS = 8'h08;
    localparam logic [7:0] REG_IRQ_MASK   = 8'h0C;

    // Channel n occupies CH_BASE + CH_STRIDE*n; stride is one address nibble
    localparam logic [7:0] CH_BASE   = 8'h20;
    localparam logic [7:0] CH_STRIDE = 8'h10;

    localparam logic [3:0] CH_OFF_POS    = 4'h0;
    localparam logic [3:0] CH_OFF_VEL    = 4'h4;
    localparam logic [3:0] CH_OFF_STATUS = 4'h8;
    localparam logic [3:0] CH_OFF_CMP    = 4'hC;

    // Bit positions
    localparam int STATUS_DIR_BIT = 0;
    localparam int STATUS_ERR_BIT = 1;
    localparam int IRQ_ERR_BASE   = 0;
    localparam int IRQ_CMP_BASE   = 16;

    typedef enum logic [1:0] {
        STEP_NONE    = 2'd0,
        STEP_FWD     = 2'd1,
        STEP_REV     = 2'd2,
        STEP_ILLEGAL = 2'd3
    } step_e;

    // Forward Gray sequence on {A,B}: 00 -> 01 -> 11 -> 10 -> 00
    function automatic logic [1:0] gray_next(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // A single-bit change that is not the forward successor must be a reverse step
    function automatic step_e decode_step(input logic [1:0] prev, input logic [1:0] cur);
        if (cur == prev)
            return STEP_NONE;
        else if ((cur ^ prev) == 2'b11)
            return STEP_ILLEGAL;
        else if (cur == gray_next(prev))
            return STEP_FWD;
        else
            return STEP_REV;
    endfunction

endpackage

// File: rtl/encoder_channel.sv
// ---------------------------------------------------------------------------
// encoder_channel
//  One quadrature channel: 2-FF synchroniser per pin, previous-state register,
//  x4 decode, signed wrapping position, windowed saturating velocity,
//  direction, sticky illegal-transition error and optional compare.
//
//  Configuration macro: ENC_MMIO_COMPARE_EN (compare register + event).
//
//  Ports
//   clk_i, rst_i       clock, asynchronous active-high reset
//   en_i               channel enable (counting only; pins always tracked)
//   clr_i              clear-position pulse, wins over a same-cycle step
//   win_end_i          last cycle of the shared velocity window
//   err_clr_i          clear sticky error (a same-cycle error still sets it)
//   cmp_we_i/wdata_i   compare register write
//   enc_a_i, enc_b_i   raw asynchronous encoder pins
//   pos_o, vel_o       position / velocity, sign-extended to 32 bits
//   cmp_o              compare register (0 when compare is not built)
//   dir_o, err_o       direction (1 = forward), sticky error
//   err_evt_o          one-cycle illegal-transition event
//   cmp_evt_o          one-cycle compare-match event
// ---------------------------------------------------------------------------
module encoder_channel
    import encoder_pkg::*;
#(
    parameter int POS_W = 32,
    parameter int VEL_W = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        clr_i,
    input  logic        win_end_i,
    input  logic        err_clr_i,
    input  logic        cmp_we_i,
    input  logic [31:0] cmp_wdata_i,
    input  logic        enc_a_i,
    input  logic        enc_b_i,
    output logic [31:0] pos_o,
    output logic [31:0] vel_o,
    output logic [31:0] cmp_o,
    output logic        dir_o,
    output logic        err_o,
    output logic        err_evt_o,
    output logic        cmp_evt_o
);

    // Saturation limit +/-(2^(VEL_W-1)-1), held one bit wider than the register
    localparam logic [63:0]        VMAX64 = (64'd1 << (VEL_W - 1)) - 64'd1;
    localparam logic signed [VEL_W:0] VMAX = $signed(VMAX64[VEL_W:0]);

    logic [1:0]              a_sync_q, b_sync_q;   // [0] first stage, [1] second
    logic [1:0]              prev_q;
    logic [1:0]              cur;
    step_e                   step_kind;
    logic signed [1:0]       step;

    logic [POS_W-1:0]        pos_q, pos_d, pos_step;
    logic signed [VEL_W-1:0] acc_q, acc_d, vel_q, vel_d;
    logic signed [VEL_W:0]   acc_sum, acc_sat;
    logic                    dir_q, dir_d;
    logic                    err_q, err_d;

    assign cur       = {a_sync_q[1], b_sync_q[1]};
    assign step_kind = decode_step(prev_q, cur);

    // Disabled channels decode nothing, so a re-enable never sees a stale edge:
    // prev_q keeps following the pins regardless of enable.
    always_comb begin
        step = 2'sd0;
        if (en_i) begin
            case (step_kind)
                STEP_FWD: step = 2'sd1;
                STEP_REV: step = -2'sd1;
                default:  step = 2'sd0;
            endcase
        end
    end

    assign err_evt_o = en_i && (step_kind == STEP_ILLEGAL);

    always_comb begin
        pos_step = pos_q + POS_W'(step);
        pos_d    = pos_q;
        if (clr_i)
            pos_d = '0;
        else if (step != 2'sd0)
            pos_d = pos_step;
    end

    always_comb begin
        dir_d = dir_q;
        if (step != 2'sd0)
            dir_d = (step_kind == STEP_FWD);
        err_d = err_evt_o | (err_q & ~err_clr_i);
    end

    // Velocity: the window-end cycle's own step is included in the sample
    always_comb begin
        acc_sum = (VEL_W+1)'(acc_q) + (VEL_W+1)'(step);
        if (acc_sum > VMAX)
            acc_sat = VMAX;
        else if (acc_sum < -VMAX)
            acc_sat = -VMAX;
        else
            acc_sat = acc_sum;
        acc_d = en_i ? acc_sat[VEL_W-1:0] : '0;
        vel_d = vel_q;
        if (win_end_i) begin
            vel_d = acc_d;
            acc_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_sync_q <= '0;
            b_sync_q <= '0;
            prev_q   <= '0;
            pos_q    <= '0;
            acc_q    <= '0;
            vel_q    <= '0;
            dir_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            a_sync_q <= {a_sync_q[0], enc_a_i};
            b_sync_q <= {b_sync_q[0], enc_b_i};
            prev_q   <= cur;
            pos_q    <= pos_d;
            acc_q    <= acc_d;
            vel_q    <= vel_d;
            dir_q    <= dir_d;
            err_q    <= err_d;
        end
    end

    assign pos_o = 32'($signed(pos_q));
    assign vel_o = 32'(vel_q);
    assign dir_o = dir_q;
    assign err_o = err_q;

`ifdef ENC_MMIO_COMPARE_EN
    logic [31:0] cmp_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cmp_q <= '0;
        else if (cmp_we_i)
            cmp_q <= cmp_wdata_i;
    end

    assign cmp_o     = cmp_q;
    // Fires only when a counted step lands on the compare value
    assign cmp_evt_o = !clr_i && (step != 2'sd0) && (pos_step == cmp_q[POS_W-1:0]);
`else
    logic unused_cmp;
    assign unused_cmp = ^{cmp_we_i, cmp_wdata_i};
    assign cmp_o      = '0;
    assign cmp_evt_o  = 1'b0;
`endif

endmodule

// File: rtl/encoder_mmio_multi.sv
// ---------------------------------------------------------------------------
// encoder_mmio_multi
//  Multi-channel x4 quadrature encoder peripheral on the CPU MMIO bus.
//  Top level holds the shared velocity window counter, bus decode, CTRL,
//  IRQ_STATUS / IRQ_MASK, the registered read mux and the irq output.
//
//  Configuration macro: ENC_MMIO_COMPARE_EN (per-channel COMPARE register and
//  IRQ_STATUS[16+n] compare events). Undefined: COMPARE reads 0 and the upper
//  IRQ_STATUS half stays 0.
//
//  Bus semantics: bus_we / bus_re are single-cycle strobes with no handshake
//  (always accepted). A write takes effect at the edge that samples bus_we;
//  a read loads bus_rdata at the edge that samples bus_re, and bus_rdata
//  holds its value otherwise.
//
//  Ports
//   clk, reset            clock, asynchronous active-high reset
//   bus_addr[31:0]        byte address, bits [7:0] decoded
//   bus_we, bus_re        write / read strobes
//   bus_wdata[31:0]       write data
//   bus_rdata[31:0]       registered read data
//   enc_a, enc_b[NCH-1:0] asynchronous encoder pins
//   irq                   registered |(IRQ_STATUS & IRQ_MASK)
//
//  With 8 decoded address bits, channels 14 and 15 (NCH = 15/16) fall outside
//  the map: they still count and raise IRQ_STATUS but have no bus window.
// ---------------------------------------------------------------------------
module encoder_mmio_multi
    import encoder_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int POS_W      = 32,
    parameter int VEL_W      = 16,
    parameter int VEL_WINDOW = 1000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [31:0]    bus_addr,
    input  logic           bus_we,
    input  logic           bus_re,
    input  logic [31:0]    bus_wdata,
    output logic [31:0]    bus_rdata,
    input  logic [NCH-1:0] enc_a,
    input  logic [NCH-1:0] enc_b,
    output logic           irq
);

    localparam int WIN_W = $clog2(VEL_WINDOW);

    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic             win_end;

    logic [NCH-1:0]   ctrl_q, ctrl_d;
    logic [31:0]      mask_q, mask_d;
    logic [31:0]      status_q, status_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             irq_q, irq_d;

    logic [7:0]       addr;
    logic [3:0]       slot;
    logic [3:0]       ch_off;
    logic             ch_hit;
    logic [31:0]      w1c;
    logic [31:0]      irq_set;
    logic [31:0]      rd_val;
    logic             unused_addr;

    logic [NCH-1:0]   clr_vec, ch_err_clr, ch_cmp_we;
    logic [NCH-1:0]   ch_dir, ch_err, ch_err_evt, ch_cmp_evt;
    logic [31:0]      ch_pos [NCH];
    logic [31:0]      ch_vel [NCH];
    logic [31:0]      ch_cmp [NCH];

    assign addr        = bus_addr[7:0];
    assign unused_addr = ^bus_addr[31:8];
    assign slot        = addr[7:4] - CH_BASE[7:4];
    assign ch_off      = addr[3:0];
    assign ch_hit      = (addr[7:4] >= CH_BASE[7:4]) && (int'(slot) < NCH);

    // Shared free-running velocity window
    assign win_end   = (win_cnt_q == WIN_W'(VEL_WINDOW - 1));
    assign win_cnt_d = win_end ? '0 : win_cnt_q + 1'b1;

    // Write decode
    always_comb begin
        ctrl_d     = ctrl_q;
        mask_d     = mask_q;
        clr_vec    = '0;
        w1c        = '0;
        ch_err_clr = '0;
        ch_cmp_we  = '0;
        if (bus_we) begin
            case (addr)
                REG_CTRL:       ctrl_d  = bus_wdata[NCH-1:0];
                REG_CLR:        clr_vec = bus_wdata[NCH-1:0];
                REG_IRQ_STATUS: w1c     = bus_wdata;
                REG_IRQ_MASK:   mask_d  = bus_wdata;
                default:        ;
            endcase
            if (ch_hit) begin
                for (int n = 0; n < NCH; n++) begin
                    if (slot == 4'(n)) begin
                        if (ch_off == CH_OFF_STATUS)
                            ch_err_clr[n] = bus_wdata[STATUS_ERR_BIT];
                        if (ch_off == CH_OFF_CMP)
                            ch_cmp_we[n] = 1'b1;
                    end
                end
            end
        end
    end

    // IRQ status: a new event wins over a same-cycle write-1-to-clear
    always_comb begin
        irq_set = '0;
        for (int n = 0; n < NCH; n++) begin
            irq_set[IRQ_ERR_BASE + n] = ch_err_evt[n];
            irq_set[IRQ_CMP_BASE + n] = ch_cmp_evt[n];
        end
        status_d = irq_set | (status_q & ~w1c);
        irq_d    = |(status_q & mask_q);
    end

    // Read mux
    always_comb begin
        rd_val = '0;
        case (addr)
            REG_CTRL:       rd_val = 32'(ctrl_q);
            REG_IRQ_STATUS: rd_val = status_q;
            REG_IRQ_MASK:   rd_val = mask_q;
            default:        ;
        endcase
        if (ch_hit) begin
            for (int n = 0; n < NCH; n++) begin
                if (slot == 4'(n)) begin
                    case (ch_off)
                        CH_OFF_POS:    rd_val = ch_pos[n];
                        CH_OFF_VEL:    rd_val = ch_vel[n];
                        CH_OFF_STATUS: rd_val = {30'b0, ch_err[n], ch_dir[n]};
                        CH_OFF_CMP:    rd_val = ch_cmp[n];
                        default:       ;
                    endcase
                end
            end
        end
        rdata_d = bus_re ? rd_val : rdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_cnt_q <= '0;
            ctrl_q    <= '0;
            mask_q    <= '0;
            status_q  <= '0;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            win_cnt_q <= win_cnt_d;
            ctrl_q    <= ctrl_d;
            mask_q    <= mask_d;
            status_q  <= status_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
        end
    end

    assign bus_rdata = rdata_q;
    assign irq       = irq_q;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        encoder_channel #(
            .POS_W (POS_W),
            .VEL_W (VEL_W)
        ) u_ch (
            .clk_i       (clk),
            .rst_i       (reset),
            .en_i        (ctrl_q[g]),
            .clr_i       (clr_vec[g]),
            .win_end_i   (win_end),
            .err_clr_i   (ch_err_clr[g]),
            .cmp_we_i    (ch_cmp_we[g]),
            .cmp_wdata_i (bus_wdata),
            .enc_a_i     (enc_a[g]),
            .enc_b_i     (enc_b[g]),
            .pos_o       (ch_pos[g]),
            .vel_o       (ch_vel[g]),
            .cmp_o       (ch_cmp[g]),
            .dir_o       (ch_dir[g]),
            .err_o       (ch_err[g]),
            .err_evt_o   (ch_err_evt[g]),
            .cmp_evt_o   (ch_cmp_evt[g])
        );
    end

endmodule

// File: tb/tb_encoder_mmio_multi.sv
// ---------------------------------------------------------------------------
// tb_encoder_mmio_multi
//  Directed bench for encoder_mmio_multi, built with NCH=2, POS_W=8,
//  VEL_W=16, VEL_WINDOW=100. Honours ENC_MMIO_COMPARE_EN for the compare step.
// ---------------------------------------------------------------------------
module tb_encoder_mmio_multi;

    localparam int NCH        = 2;
    localparam int POS_W      = 8;
    localparam int VEL_W      = 16;
    localparam int VEL_WINDOW = 100;

    // Clock / reset
    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [31:0]    bus_addr = '0;
    logic           bus_we = 1'b0;
    logic           bus_re = 1'b0;
    logic [31:0]    bus_wdata = '0;
    logic [31:0]    bus_rdata;
    logic [NCH-1:0] enc_a, enc_b;
    logic           irq;

    logic [1:0]     ab0 = 2'b00;
    logic [1:0]     ab1 = 2'b00;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    // Cycles since reset release; window ends on edges where cyc % 100 == 99
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    assign enc_a = {ab1[1], ab0[1]};
    assign enc_b = {ab1[0], ab0[0]};

    encoder_mmio_multi #(
        .NCH        (NCH),
        .POS_W      (POS_W),
        .VEL_W      (VEL_W),
        .VEL_WINDOW (VEL_WINDOW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus_addr  (bus_addr),
        .bus_we    (bus_we),
        .bus_re    (bus_re),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .irq       (irq)
    );

    // Gray sequence on {A,B}: 00 -> 01 -> 11 -> 10 -> 00 is forward
    function automatic logic [1:0] gfwd(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] grev(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_addr  = a;
        bus_wdata = d;
        bus_we    = 1'b1;
        @(negedge clk);
        bus_we    = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus_addr = a;
        bus_re   = 1'b1;
        @(negedge clk);
        bus_re   = 1'b0;
        d        = bus_rdata;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    // One legal step on each channel selected by m, then gap-1 idle cycles
    task automatic step(input logic [1:0] m, input bit fwd, input int gap);
        @(negedge clk);
        if (m[0]) ab0 = fwd ? gfwd(ab0) : grev(ab0);
        if (m[1]) ab1 = fwd ? gfwd(ab1) : grev(ab1);
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic wait_window_start();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((cyc % VEL_WINDOW) != 1 && n < 3 * VEL_WINDOW);
        if ((cyc % VEL_WINDOW) != 1) begin
            checks++;
            errors++;
            $error("FAIL window_wait: no window start after %0d cycles", n);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_rdata", bus_rdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;
        read_check("rst_ctrl", 32'h00, 32'h0);
        read_check("rst_irq_status", 32'h08, 32'h0);
        read_check("rst_pos0", 32'h20, 32'h0);

        // ---------------- 1: reset mid-count ----------------
        bus_write(32'h00, 32'h1);
        repeat (3) step(2'b01, 1'b1, 3);
        read_check("t1_pos0_before_reset", 32'h20, 32'h3);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("t1_rdata_async", bus_rdata, 32'h0);
        check("t1_irq_async", {31'b0, irq}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        read_check("t1_ctrl", 32'h00, 32'h0);
        read_check("t1_pos0", 32'h20, 32'h0);
        repeat (2) step(2'b01, 1'b1, 3);
        read_check("t1_pos0_disabled", 32'h20, 32'h0);
        read_check("t1_status0", 32'h28, 32'h0);

        // ---------------- 2: fwd/rev count, disabled channel ----------------
        bus_write(32'h00, 32'h1);
        repeat (10) step(2'b11, 1'b1, 3);
        read_check("t2_pos0_fwd10", 32'h20, 32'd10);
        read_check("t2_status0_fwd", 32'h28, 32'h1);
        repeat (4) step(2'b11, 1'b0, 3);
        read_check("t2_pos0", 32'h20, 32'd6);
        read_check("t2_status0_rev", 32'h28, 32'h0);
        read_check("t2_pos1_disabled", 32'h30, 32'h0);
        read_check("t2_clr_reads0", 32'h04, 32'h0);
        read_check("t2_unmapped_10", 32'h10, 32'h0);
        bus_write(32'h40, 32'h5);
        read_check("t2_absent_ch2", 32'h40, 32'h0);
        bus_write(32'h00, 32'h3);
        repeat (4) @(negedge clk);
        read_check("t2_pos1_no_stale", 32'h30, 32'h0);
        step(2'b10, 1'b1, 3);
        read_check("t2_pos1_one", 32'h30, 32'h1);
        read_check("t2_ctrl", 32'h00, 32'h3);

        // ---------------- 3: POS_W=8 wrap, clear wins ----------------
        bus_write(32'h04, 32'h1);
        read_check("t3_pos0_cleared", 32'h20, 32'h0);
        read_check("t3_pos1_kept", 32'h30, 32'h1);
        repeat (127) step(2'b01, 1'b1, 3);
        read_check("t3_pos0_127", 32'h20, 32'h0000_007F);
        step(2'b01, 1'b1, 3);
        read_check("t3_pos0_wrap", 32'h20, 32'hFFFF_FF80);
        // Pin change at N0 is counted at the 3rd edge after it; CLR write lands on that edge
        @(negedge clk);
        ab0 = gfwd(ab0);
        @(negedge clk);
        @(negedge clk);
        bus_addr  = 32'h04;
        bus_wdata = 32'h1;
        bus_we    = 1'b1;
        @(negedge clk);
        bus_we    = 1'b0;
        read_check("t3_clr_wins", 32'h20, 32'h0);
        read_check("t3_irq_status", 32'h08, 32'h0);

        // ---------------- 4: illegal transition, IRQ, W1C ----------------
        bus_write(32'h0C, 32'h1);
        @(negedge clk);
        ab0 = ab0 ^ 2'b11;
        repeat (3) @(negedge clk);
        read_check("t4_status0_err", 32'h28, 32'h3);
        read_check("t4_irq_status", 32'h08, 32'h1);
        check("t4_irq", {31'b0, irq}, 32'h1);
        read_check("t4_pos0_no_count", 32'h20, 32'h0);
        bus_write(32'h08, 32'h1);
        check("t4_irq_lag", {31'b0, irq}, 32'h1);
        @(negedge clk);
        check("t4_irq_cleared", {31'b0, irq}, 32'h0);
        read_check("t4_irq_status_w1c", 32'h08, 32'h0);
        read_check("t4_err_sticky", 32'h28, 32'h3);
        bus_write(32'h28, 32'h2);
        read_check("t4_err_cleared", 32'h28, 32'h1);

        // ---------------- 5: velocity window ----------------
        wait_window_start();
        repeat (25) step(2'b01, 1'b1, 1);
        wait_window_start();
        read_check("t5_vel0_25", 32'h24, 32'd25);
        read_check("t5_pos0_25", 32'h20, 32'd25);
        read_check("t5_vel1_idle", 32'h34, 32'h0);
        wait_window_start();
        read_check("t5_vel0_idle", 32'h24, 32'h0);
        repeat (3) step(2'b01, 1'b0, 1);
        wait_window_start();
        read_check("t5_vel0_neg3", 32'h24, 32'hFFFF_FFFD);
        read_check("t5_pos0_22", 32'h20, 32'd22);

        // ---------------- 6: compare ----------------
        bus_write(32'h08, 32'hFFFF_FFFF);
        bus_write(32'h04, 32'h1);
        bus_write(32'h0C, 32'hFFFF_0000);
        bus_write(32'h2C, 32'h5);
`ifdef ENC_MMIO_COMPARE_EN
        read_check("t6_cmp_rw", 32'h2C, 32'h5);
        repeat (4) step(2'b01, 1'b1, 3);
        read_check("t6_no_match_yet", 32'h08, 32'h0);
        check("t6_irq_low", {31'b0, irq}, 32'h0);
        step(2'b01, 1'b1, 3);
        read_check("t6_match", 32'h08, 32'h0001_0000);
        check("t6_irq_high", {31'b0, irq}, 32'h1);
`else
        read_check("t6_cmp_absent", 32'h2C, 32'h0);
        repeat (5) step(2'b01, 1'b1, 3);
        read_check("t6_no_cmp_status", 32'h08, 32'h0);
        check("t6_no_cmp_irq", {31'b0, irq}, 32'h0);
`endif
        read_check("t6_pos0_5", 32'h20, 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
